// File: rtl/pe_array_wavefront.sv
// Linear systolic array of B processing elements computing the unit-cost edit distance
// between a query of up to B bases and a valid/ready reference stream.
module pe_array_wavefront #(
   parameter int B   = 8,
   parameter int W   = 8,
   parameter int QLW = $clog2(B+1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           mode,
   input  logic [QLW-1:0] q_len,
   input  logic [3*B-1:0] q_bases,
   input  logic           r_valid,
   input  logic [2:0]     r_base,
   input  logic           r_last,
   output logic           r_ready,
   output logic           busy,
   output logic [W-1:0]   score,
   output logic           score_valid
);
   localparam logic [W-1:0] SMAX = {W{1'b1}};
   localparam int CW = $clog2(B+1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
   state_t state;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] a);
      return (a == SMAX) ? SMAX : a + W'(1);
   endfunction

   function automatic logic [W-1:0] sat_const(input int v);
      return (v >= int'(SMAX)) ? SMAX : W'(v);
   endfunction

   function automatic logic [W-1:0] min2(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Codes 4..7 all have bit 2 set and behave as N, which never matches.
   function automatic logic is_mm(input logic [2:0] q, input logic [2:0] r);
      return (q[2] | r[2]) ? 1'b1 : (q != r);
   endfunction

   logic [3*B-1:0] qb;
   logic           m_reg;
   logic [CW-1:0]  qn;
   logic [CW-1:0]  qn_in;
   logic [CW-1:0]  dcnt;
   logic [W-1:0]   run_min;

   logic [W-1:0]   d  [B];
   logic [W-1:0]   dg [B];
   logic [B-2:0]   pv;
   logic [2:0]     pb [B-1];

   logic           hs;
   logic           adv;
   logic [B-1:0]   vin;
   logic [2:0]     bin   [B];
   logic [W-1:0]   up_in [B];
   logic [W-1:0]   nxt   [B];
   logic           sel_v;
   logic [W-1:0]   sel_n;
   logic [W-1:0]   sel_d;

   always_comb begin
      qn_in = CW'(B);
      if (q_len != '0 && int'(q_len) <= B)
         qn_in = CW'(q_len);
   end

   // PE i sees beat j one step after PE i-1: up_in is D[i][j], dg holds D[i][j-1],
   // d holds D[i+1][j-1]. PE 0 derives its boundary row from its own dg.
   always_comb begin
      hs    = (state == STREAM) && r_valid;
      adv   = hs || (state == DRAIN && dcnt < CW'(B));
      vin   = '0;
      sel_v = 1'b0;
      sel_n = '0;
      sel_d = '0;
      for (int i = 0; i < B; i++) begin
         bin[i]   = '0;
         up_in[i] = '0;
         nxt[i]   = '0;
      end
      for (int i = 0; i < B; i++) begin
         if (i == 0) begin
            vin[0]   = hs;
            bin[0]   = r_base;
            up_in[0] = m_reg ? '0 : sat_inc(dg[0]);
         end else begin
            vin[i]   = pv[i-1];
            bin[i]   = pb[i-1];
            up_in[i] = d[i-1];
         end
         nxt[i] = min2(min2(is_mm(qb[3*i +: 3], bin[i]) ? sat_inc(dg[i]) : dg[i],
                            sat_inc(up_in[i])),
                       sat_inc(d[i]));
         if (qn == CW'(i+1)) begin
            sel_v = vin[i];
            sel_n = nxt[i];
            sel_d = d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < B; i++) begin
            d[i]  <= '0;
            dg[i] <= '0;
         end
         for (int i = 0; i < B-1; i++) pb[i] <= '0;
         pv      <= '0;
         run_min <= '0;
      end else if (state == IDLE && start) begin
         for (int i = 0; i < B; i++) begin
            d[i]  <= sat_const(i+1);
            dg[i] <= sat_const(i);
         end
         pv      <= '0;
         run_min <= sat_const(int'(qn_in));
      end else if (adv) begin
         for (int i = 0; i < B; i++) begin
            if (vin[i]) begin
               d[i]  <= nxt[i];
               dg[i] <= up_in[i];
            end
         end
         for (int i = 0; i < B-1; i++) begin
            pv[i] <= vin[i];
            pb[i] <= bin[i];
         end
         if (sel_v)
            run_min <= min2(run_min, sel_n);
      end
   end

   // DRAIN spends B advancing cycles plus one capture cycle before DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         r_ready     <= 1'b0;
         busy        <= 1'b0;
         score       <= '0;
         score_valid <= 1'b0;
         m_reg       <= 1'b0;
         qn          <= '0;
         qb          <= '0;
         dcnt        <= '0;
      end else begin
         score_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg   <= mode;
                  qn      <= qn_in;
                  qb      <= q_bases;
                  r_ready <= 1'b1;
                  busy    <= 1'b1;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               if (hs && r_last) begin
                  r_ready <= 1'b0;
                  dcnt    <= '0;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (dcnt == CW'(B)) begin
                  score       <= m_reg ? run_min : sel_d;
                  score_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end else begin
                  dcnt <= dcnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_array_wavefront.sv
// Bench for pe_array_wavefront: a W=8 and a W=3 instance share stimulus; results are
// checked against a queue of expected scores filled when each job is issued.
`timescale 1ns/1ps
module tb_pe_array_wavefront;
   localparam int B   = 8;
   localparam int QLW = $clog2(B+1);

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           mode = 1'b0;
   logic [QLW-1:0] q_len = '0;
   logic [3*B-1:0] q_bases = '0;
   logic           r_valid = 1'b0;
   logic [2:0]     r_base = '0;
   logic           r_last = 1'b0;
   logic           r_ready, busy, score_valid;
   logic [7:0]     score;
   logic           r_ready3, busy3, score_valid3;
   logic [2:0]     score3;

   int n_cmp = 0;
   int n_bad = 0;
   int q8[$];
   int q3[$];

   always #5 clk = ~clk;

   pe_array_wavefront #(.B(B), .W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .q_len(q_len),
      .q_bases(q_bases), .r_valid(r_valid), .r_base(r_base), .r_last(r_last),
      .r_ready(r_ready), .busy(busy), .score(score), .score_valid(score_valid));

   pe_array_wavefront #(.B(B), .W(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .q_len(q_len),
      .q_bases(q_bases), .r_valid(r_valid), .r_base(r_base), .r_last(r_last),
      .r_ready(r_ready3), .busy(busy3), .score(score3), .score_valid(score_valid3));

   typedef struct {
      bit          md;
      int          ql;
      logic [95:0] qb;
      logic [95:0] rb;
      int          rl;
      int          gap;
      bit          ext;
      int          exp;
   } job_t;

   job_t jobs[10];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [95:0] enc(input string s);
      logic [95:0] v;
      logic [2:0]  c;
      v = '0;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "A": c = 3'd0;
            "C": c = 3'd1;
            "G": c = 3'd2;
            "T": c = 3'd3;
            default: c = 3'd4;
         endcase
         v[3*i +: 3] = c;
      end
      return v;
   endfunction

   // Plain column-by-column DP over the unsaturated edit distance.
   function automatic int model(input bit md, input int ql, input logic [95:0] qb,
                                input logic [95:0] rb, input int rl);
      int prev[9];
      int cur[9];
      int best;
      int c;
      int t;
      logic [2:0] a, b;
      for (int i = 0; i < 9; i++) begin
         prev[i] = i;
         cur[i]  = 0;
      end
      best = prev[ql];
      for (int j = 1; j <= rl; j++) begin
         cur[0] = md ? 0 : j;
         for (int i = 1; i <= ql; i++) begin
            a = qb[3*(i-1) +: 3];
            b = rb[3*(j-1) +: 3];
            c = (a >= 3'd4 || b >= 3'd4 || a != b) ? 1 : 0;
            t = prev[i-1] + c;
            if (prev[i] + 1 < t) t = prev[i] + 1;
            if (cur[i-1] + 1 < t) t = cur[i-1] + 1;
            cur[i] = t;
         end
         prev = cur;
         if (cur[ql] < best) best = cur[ql];
      end
      return md ? best : prev[ql];
   endfunction

   always @(negedge clk) begin
      if (score_valid === 1'b1 || score_valid3 === 1'b1) begin
         chk("sv_w3_vs_w8", score_valid3, score_valid);
         if (q8.size() == 0) begin
            chk("unexpected_score_valid", 1, 0);
         end else begin
            chk("score_w8", score, q8.pop_front());
            chk("score_w3", score3, q3.pop_front());
         end
      end
   end

   task automatic run_job(input string tag, input bit md, input int ql, input logic [95:0] qb,
                          input logic [95:0] rb, input int rl, input int gap, input bit ext,
                          input int exp);
      int   lat;
      logic pbusy;
      q8.push_back(exp > 255 ? 255 : exp);
      q3.push_back(exp > 7 ? 7 : exp);
      start   = 1'b1;
      mode    = md;
      q_len   = QLW'(ql);
      q_bases = qb[3*B-1:0];
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_stream"}, busy, 1);
      for (int j = 0; j < rl; j++) begin
         chk({tag, "_ready_beat"}, r_ready, 1);
         r_valid = 1'b1;
         r_base  = rb[3*j +: 3];
         r_last  = (j == rl-1);
         if (ext && j == 1) begin
            start = 1'b1;
            mode  = ~md;
            q_len = QLW'(1);
         end
         @(posedge clk); #1;
         start   = 1'b0;
         r_valid = 1'b0;
         r_last  = 1'b0;
         if (j < rl-1)
            for (int g = 0; g < gap; g++) begin
               r_base = 3'($urandom_range(0, 7));
               @(posedge clk); #1;
            end
      end
      lat   = 0;
      pbusy = busy;
      if (ext) r_valid = 1'b1;
      while (score_valid !== 1'b1 && lat < 40) begin
         pbusy  = busy;
         r_base = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
         lat++;
      end
      r_valid = 1'b0;
      chk({tag, "_latency"}, lat, B+1);
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_busy_before"}, pbusy, 1);
      chk({tag, "_ready_done"}, r_ready, 0);
      @(posedge clk); #1;
      chk({tag, "_sv_one_cycle"}, score_valid, 0);
      chk({tag, "_score_hold"}, score, exp > 255 ? 255 : exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] rq, rr;
      int          rql, rrl, e;
      bit          rmd;

      jobs[0] = '{1'b0, 4, enc("ACGT"),     enc("ACGT"),         4,  0, 1'b0, 0};
      jobs[1] = '{1'b0, 4, enc("ACGT"),     enc("AGT"),          3,  0, 1'b0, 1};
      jobs[2] = '{1'b0, 3, enc("AGT"),      enc("ACGT"),         4,  0, 1'b0, 1};
      jobs[3] = '{1'b1, 2, enc("CG"),       enc("TTCGTT"),       6,  0, 1'b0, 0};
      jobs[4] = '{1'b0, 2, enc("CG"),       enc("TTCGTT"),       6,  0, 1'b0, 4};
      jobs[5] = '{1'b0, 2, enc("NA"),       enc("NA"),           2,  3, 1'b1, 1};
      jobs[6] = '{1'b0, 0, enc("ACGTACGT"), enc("ACGT"),         4,  1, 1'b0, 4};
      jobs[7] = '{1'b1, 2, enc("AC"),       enc("T"),            1,  0, 1'b0, 2};
      jobs[8] = '{1'b1, 8, enc("ACGTACGT"), enc("TTACGTACGTTT"), 12, 0, 1'b0, 0};
      jobs[9] = '{1'b0, 4, enc("AAAA"),     enc("CCCCCCCCCCCC"), 12, 0, 1'b0, 12};

      #1;
      chk("rst_ready", r_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_score", score, 0);
      chk("rst_sv", score_valid, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", r_ready, 0);
      chk("idle_busy", busy3, 0);

      for (int k = 0; k < 10; k++)
         run_job($sformatf("job%0d", k), jobs[k].md, jobs[k].ql, jobs[k].qb, jobs[k].rb,
                 jobs[k].rl, jobs[k].gap, jobs[k].ext, jobs[k].exp);

      // Abandon a job after two beats; the previous scores are nonzero at this point.
      start   = 1'b1;
      mode    = 1'b0;
      q_len   = QLW'(4);
      rq      = enc("ACGT");
      q_bases = rq[3*B-1:0];
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         r_valid = 1'b1;
         r_base  = rq[3*j +: 3];
         r_last  = 1'b0;
         @(posedge clk); #1;
      end
      r_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_ready", r_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_score", score, 0);
      chk("midrst_score_w3", score3, 0);
      chk("midrst_sv", score_valid, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (B+6) @(posedge clk);
      #1;
      chk("postrst_busy", busy, 0);
      run_job("fresh", 1'b0, 4, enc("ACGT"), enc("ACGT"), 4, 0, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         rmd = 1'($urandom_range(0, 1));
         rql = $urandom_range(1, B);
         rrl = $urandom_range(1, 10);
         rq  = '0;
         rr  = '0;
         for (int i = 0; i < rql; i++) rq[3*i +: 3] = 3'($urandom_range(0, 4));
         for (int j = 0; j < rrl; j++) rr[3*j +: 3] = 3'($urandom_range(0, 4));
         e = model(rmd, rql, rq, rr, rrl);
         run_job($sformatf("rand%0d", k), rmd, rql, rq, rr, rrl, $urandom_range(0, 2), 1'b0, e);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty_w8", q8.size(), 0);
      chk("sb_empty_w3", q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pe_array_wavefront.md
Name: pe_array_wavefront

Overview:
- Parametrised linear systolic array of B processing elements (PEs). Computes the unit-cost edit distance between a query (up to B bases) and a streamed reference of arbitrary length.
- Successor to the fixed 4-PE anti-diagonal array. Adds:
  - a B-wide array;
  - runtime query length;
  - a global / semi-global mode;
  - score saturation;
  - an internal sequencing FSM, replacing the external ctr;
  - a valid/ready reference stream and a one-cycle result pulse.
- Sits between the sequence-fetch logic and the alignment result collector.

Parameters:
- B, 8: number of PEs; also the maximum query length.
- W, 8: score width in bits. All DP cells saturate at 2^W-1.
- QLW, $clog2(B+1): width of q_len.

Ports:
- clk, input, 1: clock; everything is rising-edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a job. Honoured only in IDLE.
- mode, input, 1: 0 = global, 1 = semi-global (free leading/trailing reference gaps). Sampled on start.
- q_len, input, QLW: query length, range 1..B. Sampled on start. Values 0 or >B are clamped to B.
- q_bases, input, 3*B: query bases; base i is at [3i+2:3i]. Sampled on start.
- r_valid, input, 1: reference beat valid.
- r_base, input, 3: reference base.
- r_last, input, 1: marks the final reference beat.
- r_ready, output, 1: array can accept a reference beat.
- busy, output, 1: a job is in progress (STREAM or DRAIN).
- score, output, W: edit distance. Holds its value until the next score_valid.
- score_valid, output, 1: one-cycle pulse when score updates.

Behaviour:
- Base encoding:
  - A=0, C=1, G=2, T=3, N=4.
  - Codes 5-7 are treated as N.
  - N mismatches every base, including N.
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - r_ready=0, busy=0, score=0, score_valid=0.
  - All PE score and base registers are cleared.
  - Applies mid-job: the job is abandoned and no score_valid is produced.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - r_ready=0, busy=0.
  - On start=1: latch mode, q_len and q_bases; initialise the boundary column D[i][0]=i for i=0..q_len; go to STREAM.
- STREAM:
  - r_ready=1, busy=1.
  - The array advances one step only on a handshake (r_valid & r_ready). With no handshake, all PE state holds.
  - Boundary row D[0][j]: j (saturated) in global mode; 0 in semi-global mode.
  - A handshake with r_last=1 moves the FSM to DRAIN.
- DRAIN:
  - r_ready=0, busy=1.
  - The array advances every cycle for exactly B cycles, then the FSM goes to DONE.
  - PEs with index ≥ q_len compute but are ignored.
- DONE:
  - score and score_valid=1 are registered for one cycle; busy=0; next state is IDLE.
  - Latency: score_valid is high exactly B+1 cycles after the r_last handshake edge, independent of gaps earlier in the stream.
- PE i (holds query base i):
  - D[i+1][j] = min(D[i][j-1] + (q_i != r_j), D[i][j] + 1, D[i+1][j-1] + 1).
  - Adds saturate at 2^W-1; the min operates on saturated values.
  - PE i processes reference beat j one array step after PE i-1.
- Result, with M = number of reference beats:
  - Global: D[q_len][M].
  - Semi-global: min over j=0..M of D[q_len][j], tracked by a running-min register on PE q_len-1's output (initialised to q_len).
- Other rules:
  - start while busy, or during DONE, is ignored (the job is not restarted).
  - r_valid outside STREAM is ignored.
  - M=1 is legal (r_last on the first beat).

Test Plan:
- Exact match, global: B=8, W=8, q_len=4, Q=ACGT, R=A,C,G,T back-to-back, r_last on T → score=0, score_valid exactly 9 cycles after the r_last edge, busy falls the same cycle.
- Deletion, global: Q=ACGT, R=A,G,T → score=1. Insertion: Q=AGT (q_len=3), R=A,C,G,T → score=1.
- Mode contrast: Q=CG (q_len=2), R=T,T,C,G,T,T → semi-global score=0; global score=4.
- N handling and stalls: Q=NA, R=N,A with 3 idle r_valid=0 cycles between beats → score=1, latency from r_last unchanged; start pulsed mid-stream → ignored, result unaffected.
- Saturation: W=3, Q=AAAA (q_len=4), R=12×C, global → score=7 (saturated, not 12 mod 8).
- Reset mid-job: assert reset during STREAM after 2 beats → r_ready=0, busy=0, score=0 immediately, no score_valid; a fresh job afterwards (Q=ACGT, R=ACGT) → 0.
